// File: rtl/chunked_add_seq.sv
// Sequential adder: sums two WIDTH-bit operands CHUNK bits per cycle through one
// shared CHUNK-bit adder, with a valid/ready handshake on each side.
module chunked_add_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH:0]   sum_q;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic             last_step;

  // The single shared chunk adder; idx selects which slice of the operands it sees.
  always_comb begin
    a_chunk   = CHUNK'(a_q >> (idx_q * CHUNK));
    b_chunk   = CHUNK'(b_q >> (idx_q * CHUNK));
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  assign last_step = (idx_q == LAST_IDX);

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its hold value first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;

  // NOTE: every datapath register is cleared by reset (there is no memory array
  // here), so an aborted operation leaves nothing visible behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          carry_q <= chunk_res[CHUNK];
          idx_q   <= last_step ? '0 : idx_q + IDX_W'(1);
          for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
          end
          if (last_step) sum_q[WIDTH] <= chunk_res[CHUNK];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_seq.sv
// Bench for chunked_add_seq: directed operations on a 16/4 instance checked by a
// scoreboard monitor, plus a direct check of an 8/8 (single-chunk) instance.
module tb_chunked_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [16:0] sum;

  logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [7:0]  a_1, b_1;
  logic [8:0]  sum_1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  chunked_add_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
  );

  chunked_add_seq #(.WIDTH(8), .CHUNK(8)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .busy(busy_1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h with no operation outstanding", sum);
      end else begin
        check("sum", {15'd0, sum}, {15'd0, sb.pop_front()});
      end
    end
  end

  // Present operands until accepted, record the expectation, then scramble a/b.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic [16:0] exp, output int waits);
    @(posedge clk); #1;
    in_valid = 1'b1; a = av; b = bv;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
  endtask

  // Called right after the acceptance edge with out_ready held high.
  task automatic measure(input int exp_lat, input int exp_busy);
    int cyc  = 0;
    int lat  = -1;
    int bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (out_valid && lat < 0) lat = cyc - 1;
    end while (busy && cyc < 50);
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_busy);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int waits;
    int n0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; out_ready_1 = 1'b1;

    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {15'd0, sum}, 32'd0);
    check("rst_sum_n1", {23'd0, sum_1}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic operation, latency and busy window.
    issue(16'h1234, 16'h4321, 17'h05555, waits);
    measure(4, 5);

    // Carry ripple through every chunk.
    issue(16'hFFFF, 16'h0001, 17'h10000, waits);
    measure(4, 5);
    issue(16'hFFFF, 16'hFFFF, 17'h1FFFE, waits);
    measure(4, 5);

    // Back-pressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    issue(16'h1234, 16'h4321, 17'h05555, waits);
    n0 = 0;
    @(negedge clk);
    while (!out_valid && n0 < 50) begin
      n0++;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {15'd0, sum}, 32'h05555);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Operands offered during RUN must be ignored.
    n0 = n_out;
    issue(16'h0001, 16'h0001, 17'h00002, waits);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("single_result", n_out - n0, 1);

    // Reset in the second RUN cycle discards the operation.
    n0 = n_out;
    issue(16'h1111, 16'h2222, 17'h03333, waits);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_sum", {15'd0, sum}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_out_after_reset", n_out - n0, 0);
    issue(16'h0F0F, 16'h00F1, 17'h01000, waits);
    check("first_edge_accept", waits, 0);
    measure(4, 5);

    // Single-chunk instance: one-cycle RUN.
    @(posedge clk); #1;
    in_valid_1 = 1'b1; a_1 = 8'hFF; b_1 = 8'h01;
    @(negedge clk);
    check("n1_in_ready", {31'd0, in_ready_1}, 32'd1);
    @(posedge clk); #1;
    in_valid_1 = 1'b0; a_1 = 8'h00; b_1 = 8'h00;
    @(negedge clk);
    check("n1_run_valid", {31'd0, out_valid_1}, 32'd0);
    check("n1_run_busy", {31'd0, busy_1}, 32'd1);
    @(negedge clk);
    check("n1_out_valid", {31'd0, out_valid_1}, 32'd1);
    check("n1_sum", {23'd0, sum_1}, 32'h100);
    @(negedge clk);
    check("n1_idle_valid", {31'd0, out_valid_1}, 32'd0);
    check("n1_idle_ready", {31'd0, in_ready_1}, 32'd1);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chunked_add_seq.md
CHUNKED_ADD_SEQ -- requirements
Module: chunked_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: operands a/b valid.
REQ-006 SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH: operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH: operand B, unsigned.
REQ-009 SHALL have port out_valid  output  1: sum valid.
REQ-010 SHALL have port out_ready  input  1: consumer accepts sum.
REQ-011 SHALL have port sum  output  WIDTH+1: A+B, MSB = final carry.
REQ-012 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-013 SHALL use one internal CHUNK-bit adder with carry-in, shared across all N chunk steps; no WIDTH-wide adder.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on clk edge with in_valid=1, SHALL capture a and b into registers, clear the carry register, clear the chunk index idx to 0, clear sum to 0, and enter RUN.
REQ-016 RUN: in_ready=0; each cycle SHALL add chunk idx of the captured A and B plus carry, write the CHUNK-bit result into sum[idx*CHUNK +: CHUNK], register the chunk carry-out, and increment idx.
REQ-017 RUN SHALL exit to DONE on the edge that processes idx = N-1; that edge SHALL also write sum[WIDTH] = the chunk carry-out.
REQ-018 Latency: out_valid SHALL rise exactly N cycles after the operand-acceptance edge (16/4 -> 4 cycles).
REQ-019 DONE: out_valid=1, in_ready=0; sum SHALL hold stable until out_ready=1 is sampled; then return to IDLE.
REQ-020 No DONE->RUN bypass: the next operand SHALL be accepted no earlier than the cycle after the DONE->IDLE transition; minimum issue interval is N+2 cycles.
REQ-021 in_valid, a and b SHALL be ignored outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 The arithmetic SHALL be unsigned modulo 2^(WIDTH+1) with no overflow flag; sum SHALL equal a+b exactly.
REQ-024 idx SHALL be ceil(log2(N)) bits wide, minimum 1; N=1 (CHUNK=WIDTH) SHALL be supported with a 1-cycle RUN.
REQ-025 sum SHALL be registered; out_valid, in_ready and busy SHALL be decoded from the state register only (no combinational input-to-output path).

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, idx=0, carry=0, operand registers=0, sum=0, so that out_valid=0, busy=0, in_ready=1, independent of clk.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid SHALL follow its release.
REQ-028 After rst_n rises, the first clk edge with in_valid=1 SHALL be accepted.

Verification
REQ-029 a=0x1234, b=0x4321, in_valid pulse -> out_valid 4 cycles later, sum=0x05555, busy high for the 5 cycles from acceptance until the return to IDLE (4 RUN + 1 DONE).
REQ-030 a=0xFFFF, b=0x0001 -> sum=0x10000 (carry ripples through all 4 chunk steps); a=0xFFFF, b=0xFFFF -> sum=0x1FFFE.
REQ-031 out_ready held low 3 cycles in DONE -> out_valid and sum=0x05555 stable for all 3 cycles; out_ready=1 -> IDLE the next cycle, in_ready=1.
REQ-032 in_valid=1 with a=0xAAAA during RUN of a 0x0001+0x0001 operation -> ignored, sum=0x00002, no second result.
REQ-033 rst_n pulsed low during the 2nd RUN cycle -> outputs at reset values asynchronously, no out_valid afterwards; next operation 0x0F0F+0x00F1 -> sum=0x01000.
REQ-034 WIDTH=8, CHUNK=8 (N=1): 0xFF+0x01 -> out_valid 1 cycle after acceptance, sum=0x100.
